// File: rtl/chan_blk_fifo.sv
// Per-channel block FIFO: accepts framed blocks and exposes only fully committed blocks to the link sender.
// Latency: a want is answered by have/data one clock later; a block becomes readable the cycle after its last word.
// Backpressure: the writer is never stalled; a block that does not fit is dropped whole and counted.
module chan_blk_fifo #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       wr_data,
    input  logic              wr_en,
    input  logic              want,
    output logic              have,
    output logic [15:0]       data,
    output logic [ADDR_W-1:0] blk_cnt,
    output logic [ADDR_W:0]   level,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CMP_W = ((ADDR_W > 9) ? ADDR_W : 9) + 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_FULL = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SKIP = 2'd2
    } wr_state_t;

    wr_state_t         state, state_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic [ADDR_W-1:0] cmt_ptr, cmt_ptr_n;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_n;
    logic [ADDR_W-1:0] hdr_base;
    logic [ADDR_W-1:0] free_w;
    logic [ADDR_W-1:0] mem_wa;
    logic [8:0]        wr_left, wr_left_n;
    logic [8:0]        hdr_len;
    logic [CMP_W-1:0]  free_x, need_x;
    logic              is_hdr;
    logic              hdr_fits;
    logic              mem_we;
    logic              commit;
    logic              drop_inc;
    logic              err_inc;
    logic              pop;
    logic              blk_dec;
    logic              unused_hdr_bits;
    logic [15:0]       mem [DEPTH];

    assign is_hdr          = wr_data[15];
    assign hdr_len         = wr_data[8:0];
    assign unused_hdr_bits = ^wr_data[14:9];

    // A header arriving mid-FILL aborts the open block, so its space check starts from the commit point.
    assign hdr_base = (state == FILL) ? cmt_ptr : wr_ptr;
    assign free_w   = PTR_FULL - (hdr_base - rd_ptr);
    assign free_x   = CMP_W'(free_w);
    assign need_x   = CMP_W'(hdr_len) + CMP_W'(1);
    assign hdr_fits = (free_x >= need_x);

    assign pop      = want && (rd_ptr != cmt_ptr);
    assign rd_ptr_n = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    assign blk_dec  = have && data[15];

    always_comb begin
        state_n   = state;
        wr_ptr_n  = wr_ptr;
        cmt_ptr_n = cmt_ptr;
        wr_left_n = wr_left;
        mem_we    = 1'b0;
        mem_wa    = wr_ptr;
        commit    = 1'b0;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;
        if (wr_en) begin
            if (is_hdr) begin
                if (state != IDLE) begin
                    err_inc = 1'b1;
                end
                if (hdr_fits) begin
                    mem_we   = 1'b1;
                    mem_wa   = hdr_base;
                    wr_ptr_n = hdr_base + PTR_ONE;
                    if (hdr_len == 9'd0) begin
                        commit    = 1'b1;
                        cmt_ptr_n = hdr_base + PTR_ONE;
                        state_n   = IDLE;
                    end else begin
                        wr_left_n = hdr_len;
                        state_n   = FILL;
                    end
                end else begin
                    drop_inc  = 1'b1;
                    wr_ptr_n  = hdr_base;
                    wr_left_n = hdr_len;
                    state_n   = (hdr_len == 9'd0) ? IDLE : SKIP;
                end
            end else begin
                case (state)
                    IDLE: begin
                        err_inc = 1'b1;
                    end
                    FILL: begin
                        mem_we    = 1'b1;
                        mem_wa    = wr_ptr;
                        wr_ptr_n  = wr_ptr + PTR_ONE;
                        wr_left_n = wr_left - 9'd1;
                        if (wr_left == 9'd1) begin
                            commit    = 1'b1;
                            cmt_ptr_n = wr_ptr + PTR_ONE;
                            state_n   = IDLE;
                        end
                    end
                    SKIP: begin
                        wr_left_n = wr_left - 9'd1;
                        if (wr_left == 9'd1) begin
                            state_n = IDLE;
                        end
                    end
                    default: begin
                        state_n = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            cmt_ptr  <= '0;
            rd_ptr   <= '0;
            wr_left  <= '0;
            have     <= 1'b0;
            data     <= '0;
            blk_cnt  <= '0;
            level    <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state   <= state_n;
            wr_ptr  <= wr_ptr_n;
            cmt_ptr <= cmt_ptr_n;
            rd_ptr  <= rd_ptr_n;
            wr_left <= wr_left_n;
            have    <= pop;
            if (pop) begin
                data <= mem[rd_ptr];
            end
            level <= {1'b0, cmt_ptr_n - rd_ptr_n};
            // Block count drops once the popped header has been presented on data.
            if (commit && !blk_dec) begin
                blk_cnt <= blk_cnt + PTR_ONE;
            end else if (!commit && blk_dec) begin
                blk_cnt <= blk_cnt - PTR_ONE;
            end
            if (drop_inc && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
            if (err_inc && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_chan_blk_fifo.sv
// Directed bench for chan_blk_fifo with a small memory (capacity 15) and a readout scoreboard.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: none; the bench drives one step per clock.
module tb_chan_blk_fifo;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic [15:0]       wr_data;
    logic              wr_en;
    logic              want;
    logic              have;
    logic [15:0]       data;
    logic [ADDR_W-1:0] blk_cnt;
    logic [ADDR_W:0]   level;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  err_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];

    chan_blk_fifo #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .want     (want),
        .have     (have),
        .data     (data),
        .blk_cnt  (blk_cnt),
        .level    (level),
        .drop_cnt (drop_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic we, input logic [15:0] wd, input logic wt, input logic exp_have);
        logic [15:0] ew;
        wr_en   = we;
        wr_data = wd;
        want    = wt;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        want  = 1'b0;
        chk("have", 32'(have), 32'(exp_have));
        if (exp_have && have && (exp_q.size() > 0)) begin
            ew = exp_q.pop_front();
            chk("data", 32'(data), 32'(ew));
        end
    endtask

    task automatic wr(input logic [15:0] w);
        step(1'b1, w, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [15:0] w);
        exp_q.push_back(w);
        step(1'b0, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic rd_none();
        step(1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_have"}, 32'(have), 0);
        chk({tag, "_data"}, 32'(data), 0);
        chk({tag, "_blk"}, 32'(blk_cnt), 0);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_drop"}, 32'(drop_cnt), 0);
        chk({tag, "_err"}, 32'(err_cnt), 0);
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        want    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Basic 3-word block, read back-to-back
        wr(16'h8003); wr(16'h0011); wr(16'h0022); wr(16'h0033);
        chk("t1_blk", 32'(blk_cnt), 1);
        chk("t1_level", 32'(level), 4);
        rd(16'h8003); rd(16'h0011); rd(16'h0022); rd(16'h0033);
        idle();
        chk("t1_blk_end", 32'(blk_cnt), 0);
        chk("t1_level_end", 32'(level), 0);

        // Partial block is invisible until complete
        wr(16'h8002); wr(16'h0044);
        rd_none();
        chk("t2_blk_part", 32'(blk_cnt), 0);
        chk("t2_level_part", 32'(level), 0);
        wr(16'h0055);
        chk("t2_blk", 32'(blk_cnt), 1);
        chk("t2_level", 32'(level), 3);
        rd(16'h8002); rd(16'h0044); rd(16'h0055);
        idle();
        chk("t2_blk_end", 32'(blk_cnt), 0);

        // Capacity: a 10-word block fits, a following 8-word block is dropped
        wr(16'h8009);
        for (int i = 1; i <= 9; i++) wr(16'h0100 + 16'(i));
        chk("t3_level_a", 32'(level), 10);
        chk("t3_blk_a", 32'(blk_cnt), 1);
        wr(16'h8007);
        for (int i = 1; i <= 7; i++) wr(16'h0200 + 16'(i));
        chk("t3_drop", 32'(drop_cnt), 1);
        chk("t3_level_b", 32'(level), 10);
        chk("t3_blk_b", 32'(blk_cnt), 1);
        chk("t3_err", 32'(err_cnt), 0);
        rd(16'h8009);
        for (int i = 1; i <= 9; i++) rd(16'h0100 + 16'(i));
        idle();
        chk("t3_blk_c", 32'(blk_cnt), 0);
        chk("t3_level_c", 32'(level), 0);
        wr(16'h8007);
        for (int i = 1; i <= 7; i++) wr(16'h0300 + 16'(i));
        chk("t3_blk_d", 32'(blk_cnt), 1);
        chk("t3_level_d", 32'(level), 8);
        chk("t3_drop_d", 32'(drop_cnt), 1);
        rd(16'h8007);
        for (int i = 1; i <= 7; i++) rd(16'h0300 + 16'(i));
        idle();

        // Header inside an open block aborts it
        wr(16'h8004); wr(16'h0001); wr(16'h0002); wr(16'h8001); wr(16'h00AA);
        chk("t4_err", 32'(err_cnt), 1);
        chk("t4_blk", 32'(blk_cnt), 1);
        chk("t4_level", 32'(level), 2);
        rd(16'h8001); rd(16'h00AA);
        rd_none();
        chk("t4_data_hold", 32'(data), 32'h00AA);
        idle();
        chk("t4_blk_end", 32'(blk_cnt), 0);

        // Zero-length block commits immediately; stray word in IDLE is an error
        wr(16'h8000);
        chk("t5_blk", 32'(blk_cnt), 1);
        chk("t5_level", 32'(level), 1);
        rd(16'h8000);
        rd_none();
        idle();
        chk("t5_blk_end", 32'(blk_cnt), 0);
        wr(16'h1234);
        chk("t5_err", 32'(err_cnt), 2);

        // Oversized block dropped, header during SKIP is an error and is accepted
        wr(16'h81FF);
        chk("t6_drop", 32'(drop_cnt), 2);
        chk("t6_level", 32'(level), 0);
        wr(16'h8000);
        chk("t6_err", 32'(err_cnt), 3);
        chk("t6_blk", 32'(blk_cnt), 1);
        chk("t6_level_b", 32'(level), 1);
        rd(16'h8000);
        idle();

        // Asynchronous reset mid-FILL with have asserted
        wr(16'h8001); wr(16'h0055);
        exp_q.push_back(16'h8001);
        step(1'b1, 16'h8005, 1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("arst");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        rd_none();
        wr(16'h8000);
        chk("t7_blk", 32'(blk_cnt), 1);
        chk("t7_level", 32'(level), 1);
        chk("t7_err", 32'(err_cnt), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_blk_fifo.md
Name: chan_blk_fifo

Overview:
- Per-channel block FIFO sitting between a channel's block builder and the round-robin link sender; one instance per requester slot of the sender.
- Accepts framed blocks (header word, bit 15 = 1, bits [8:0] = number of following words) and commits them atomically.
- Answers sender read requests (want) with a one-cycle registered have/data.
- Only committed (complete) blocks are ever visible to the sender; blocks that do not fit are dropped whole and counted.

Parameters:
- ADDR_W, 10, log2 of memory depth in 16-bit words; usable capacity 2^ADDR_W - 1.
- CNT_W, 16, width of drop and error counters; counters saturate.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_data  in  16  word from block builder
- wr_en  in  1  wr_data valid this cycle
- want  in  1  read request from sender; each cycle high requests one word
- have  out  1  registered: data holds a word popped by previous-cycle want
- data  out  16  popped word; holds last value when have = 0
- blk_cnt  out  ADDR_W  committed, not-yet-started blocks stored
- level  out  ADDR_W+1  committed words not yet read
- drop_cnt  out  CNT_W  blocks dropped for lack of space (saturating)
- err_cnt  out  CNT_W  framing errors (saturating)

Behaviour:
- Reset (async, all regs): wr_ptr = cmt_ptr = rd_ptr = 0; write FSM in IDLE; have = 0; data = 0; blk_cnt = 0; level = 0; drop_cnt = 0; err_cnt = 0. Memory contents are don't-care. A partial block in progress is lost; no have pulse follows reset.
- Memory: simple dual-port RAM, 2^ADDR_W x 16, synchronous write, registered read.
- Write FSM, states IDLE / FILL / SKIP; wr_left is a 9-bit counter.
  - IDLE, wr_en, header with len = wr_data[8:0]:
    - If free >= len+1, where free = 2^ADDR_W - 1 - (wr_ptr - rd_ptr) mod 2^ADDR_W: write header and advance wr_ptr.
    - If len = 0, commit immediately (cmt_ptr <= wr_ptr+1, blk_cnt+1, stay IDLE). Otherwise wr_left = len and go to FILL.
    - If free < len+1: drop_cnt+1, wr_left = len, go to SKIP (IDLE if len = 0).
  - IDLE, wr_en, non-header word: discard; err_cnt+1.
  - FILL, wr_en, non-header word: write it, advance wr_ptr, wr_left-1. On the last word (wr_left = 1), commit: cmt_ptr <= new wr_ptr, blk_cnt+1, go to IDLE.
  - FILL, wr_en, header: abort the open block (wr_ptr <= cmt_ptr), err_cnt+1, then treat the header exactly as in IDLE in the same cycle. Free space is computed from cmt_ptr.
  - SKIP, wr_en: discard word, wr_left-1; go to IDLE on the last word. A header in SKIP sets err_cnt+1 and is processed as in IDLE.
  - Space was reserved at the header, so FILL never overflows.
- Read side:
  - want && (rd_ptr != cmt_ptr): read mem[rd_ptr], rd_ptr+1, next cycle have = 1 and data = word.
  - want && (rd_ptr == cmt_ptr): next cycle have = 0, data unchanged, no pop.
  - want low: next cycle have = 0.
  - Latency is exactly 1 clock; back-to-back want gives one word per cycle.
  - A popped word with bit 15 set decrements blk_cnt in the cycle it appears on data.
- Counters:
  - Commit and header-pop in the same cycle leave blk_cnt unchanged.
  - level = cmt_ptr - rd_ptr, registered.
  - Simultaneous write and read are always legal.
  - Pointers wrap modulo 2^ADDR_W.
  - drop_cnt and err_cnt stop at all-ones.
- Uncommitted words are never readable, so a sender that sees a header is guaranteed the whole block with no gaps.

Test Plan:
- Write header 0x8003 then 0x0011, 0x0022, 0x0033; next cycle pulse want x4 back-to-back -> have = 1 for 4 cycles, each one cycle after its want, with data 0x8003, 0x0011, 0x0022, 0x0033; blk_cnt goes 1 -> 0 on the header word; level goes 4 -> 0.
- Write header 0x8002 and one data word only, then pulse want -> have = 0, blk_cnt = 0, level = 0. After the second data word is written, want returns the full block.
- ADDR_W = 4 (capacity 15): store a 10-word block, then write header 0x8007 plus 7 words -> drop_cnt = 1, level stays 10, following data is discarded. Read out the first block, then write 0x8007 again -> accepted, blk_cnt = 1.
- Write 0x8004 and 2 words, then header 0x8001 and 0x00AA -> err_cnt = 1; readout gives exactly 0x8001, 0x00AA.
- Write 0x8000 -> blk_cnt = 1 immediately. Two wants -> have for the first only (0x8000), then have = 0. A stray 0x1234 written in IDLE -> err_cnt + 1.
- Assert reset mid-FILL and while have = 1 -> have, blk_cnt, level, and counters go to 0 asynchronously. A post-reset want gives have = 0.
